// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store alignment unit:
//   - access size encodings as carried on req_size
//   - FSM state encodings for mem_access_unit
//   - bytes_of(): number of bytes moved by an access of a given size
// -----------------------------------------------------------------------------
package mem_access_pkg;

    // Access size encodings (req_size)
    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_BYTE  = 2'b01;
    localparam logic [1:0] SZ_HALF  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    // FSM state encodings
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_RESP = 3'd4;

    // Bytes transferred by an access of the given size.
    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        logic [3:0] nb;
        case (size)
            SZ_BYTE: nb = 4'd1;
            SZ_HALF: nb = 4'd2;
            SZ_WORD: nb = 4'd4;
            default: nb = 4'd8;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// -----------------------------------------------------------------------------
// mem_lane_extract
// Combinational byte-lane select and sign/zero extension of a memory word.
// The addressed lanes (starting at byte offset off_i, width given by size_i)
// are shifted down to bit 0; the bits above the access width are filled with
// zeros (uns_i=1) or copies of the access MSB (uns_i=0).
// Ports:
//   word_i  in  DATA_W  full memory word
//   off_i   in  OFF_W   byte offset of the access within the word
//   size_i  in  2       access size (mem_access_pkg encodings)
//   uns_i   in  1       1 = zero-extend, 0 = sign-extend
//   data_o  out DATA_W  right-justified, extended result
// -----------------------------------------------------------------------------
module mem_lane_extract
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shifted;
    logic [6:0]        nbits;
    logic              sign;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        nbits   = {bytes_of(size_i), 3'b000};
        // The MSB position depends on the access size; pick it with a
        // compare per bit rather than a variable-width index.
        sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (7'(i) == nbits - 7'd1) begin
                sign = shifted[i];
            end
        end
        data_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_o[i] = (7'(i) < nbits) ? shifted[i] : (sign & ~uns_i);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store alignment unit between the MIPS datapath and data memory.
// Sub-word loads pick the addressed lanes out of the read word and extend
// them; sub-word stores do a read-modify-write of the containing word.
// One request is in flight at a time (req_ready only in IDLE).
//
// Configuration macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   : misaligned requests return resp_err=1 with no memory access
//   undefined : the address bits below the access size are cleared and the
//               access proceeds normally
//   Reserved sizes (dword on a 32-bit memory) always return resp_err=1.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_size, req_uns  store flag, access size, zero-extend flag
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid/resp_ready      response handshake (response held until taken)
//   resp_data, resp_err        extended load data (0 for stores/errors), error
//   mem_addr                   word-aligned memory address
//   mem_rd, mem_we             one-cycle read / write strobes
//   mem_wdata, mem_rdata       full-word write / read data
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    // Control state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Request fields captured at accept
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    // Request decode
    logic              accept;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  low_mask;
    logic [OFF_W-1:0]  aligned_off;
    logic              rsvd_size;
    logic              req_err;
    logic              full_word;
    logic              wait_done;

    // Store merge / load extract
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] ext_data;
    logic [7:0]        lane_lo;
    logic [7:0]        lane_hi;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign wait_done  = (state_q == ST_WAIT) && (cnt_q == '0);

    assign mem_rd     = (state_q == ST_RD);
    assign mem_we     = (state_q == ST_WR);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_data  = ((state_q == ST_RESP) && !we_q && !err_q) ? ext_data : '0;

    // ---- request decode -----------------------------------------------------
    always_comb begin
        req_off   = req_addr[OFF_W-1:0];
        // Offset bits that must be zero for a naturally aligned access.
        low_mask  = OFF_W'(bytes_of(req_size) - 4'd1);
        rsvd_size = (req_size == SZ_DWORD) && (DATA_W == 32);
        full_word = (bytes_of(req_size) == 4'(NB));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        aligned_off = req_off;
        req_err     = rsvd_size || ((req_off & low_mask) != '0);
`else
        aligned_off = req_off & ~low_mask;
        req_err     = rsvd_size;
`endif
    end

    // ---- store merge: replace the addressed lanes of the read word ----------
    always_comb begin
        wdata_sh = wdata_q << {off_q, 3'b000};
        lane_lo  = 8'(off_q);
        lane_hi  = 8'(off_q) + 8'(bytes_of(size_q));
        merged   = mem_rdata;
        for (int j = 0; j < NB; j++) begin
            if ((8'(j) >= lane_lo) && (8'(j) < lane_hi)) begin
                merged[8*j +: 8] = wdata_sh[8*j +: 8];
            end
        end
    end

    // ---- FSM next state -------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we && full_word) begin
                        // Whole word is overwritten: no read needed.
                        mem_wdata_d = req_wdata;
                        state_d     = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MEM_LAT - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        mem_wdata_d = merged;
                        state_d     = ST_WR;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Captured fields are only observed while the FSM is past IDLE, so they
    // need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q   <= aligned_off;
            size_q  <= req_size;
            uns_q   <= req_uns;
            we_q    <= req_we;
            err_q   <= req_err;
            wdata_q <= req_wdata;
        end
        if (wait_done) begin
            rdata_q <= mem_rdata;
        end
    end

    mem_lane_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extract (
        .word_i (rdata_q),
        .off_i  (off_q),
        .size_i (size_q),
        .uns_i  (uns_q),
        .data_o (ext_data)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit (DATA_W=32, MEM_LAT=1).
// A word-array memory model answers the DUT's strobes; a byte-array reference
// model computes expected data, error flag, latency, strobe counts and the
// memory image after stores. Directed cases first, then random traffic.
// Honors MEM_ACCESS_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_uns;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_uns    (req_uns),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---- memory model (64 words, byte addresses 0x00..0xFF) ----
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [MEM_LAT];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        // Poison value outside read data slots exposes a mis-timed sample.
        rd_pipe[0] <= mem_rd ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // ---- reference model state ----
    logic [7:0] ref_mem [256];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] v);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = v;
        for (int k = 0; k < 4; k++) ref_mem[idx*4+k] = v[8*k +: 8];
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Byte-level behaviour of one access: result, error, response latency
    // (cycles after accept), read and write strobe counts. Updates ref_mem.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         output logic [31:0] d, output logic e, output int lat,
                         output int nrd, output int nwr);
        int nb;
        int a;
        logic [63:0] v;
        nb  = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : (size == 2'b00) ? 4 : 8;
        d   = '0;
        e   = 1'b0;
        nrd = 0;
        nwr = 0;
        lat = 1;
        if (nb > DATA_W/8) begin
            e = 1'b1;
            return;
        end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (int'(addr) % nb != 0) begin
            e = 1'b1;
            return;
        end
`endif
        a = int'(addr) - int'(addr) % nb;
        if (!we) begin
            v = '0;
            for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[a+k]) << (8*k));
            if (!uns && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
            d   = v[31:0];
            lat = MEM_LAT + 2;
            nrd = 1;
        end else begin
            for (int k = 0; k < nb; k++) ref_mem[a+k] = wdata[8*k +: 8];
            nwr = 1;
            if (nb == 4) begin
                lat = 2;
            end else begin
                lat = MEM_LAT + 3;
                nrd = 1;
            end
        end
    endtask

    // Issue one request, check everything about its execution, return the
    // observed response data.
    task automatic run(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] got);
        logic [31:0] ed;
        logic        ee;
        int          el, er, ew, lat, rd0, wr0;
        model(we, size, uns, addr, wdata, ed, ee, el, er, ew);
        @(negedge clk);
        chk({tag, ".ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_uns    = uns;
        req_addr   = {24'h0, addr};
        req_wdata  = wdata;
        resp_ready = (hold == 0);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        chk({tag, ".rd_c1"}, mem_rd, (er == 1) ? 1 : 0);
        chk({tag, ".we_c1"}, mem_we, (ew == 1 && el == 2) ? 1 : 0);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, el);
        chk({tag, ".data"}, resp_data, ed);
        chk({tag, ".err"}, resp_err, ee);
        got = resp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_v"}, resp_valid, 1);
            chk({tag, ".hold_d"}, resp_data, ed);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".done"}, resp_valid, 0);
        chk({tag, ".nrd"}, rd_cnt - rd0, er);
        chk({tag, ".nwr"}, wr_cnt - wr0, ew);
        if (ew == 1) chk({tag, ".mem"}, mem[addr[7:2]], ref_word(int'(addr[7:2])));
    endtask

    initial begin
        logic [31:0] got;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_uns    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.ready", req_ready, 1);
        chk("rst.rd", mem_rd, 0);
        chk("rst.we", mem_we, 0);
        chk("rst.rv", resp_valid, 0);
        chk("rst.err", resp_err, 0);
        chk("rst.data", resp_data, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.addr", mem_addr, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        set_word(4, 32'h808182F3);
        set_word(8, 32'h11223344);

        // Directed loads on word 0x10
        run("LW10", 1'b0, 2'b00, 1'b0, 8'h10, 0, 0, got);
        chk("LW10.k", got, 32'h808182F3);
        run("LB13", 1'b0, 2'b01, 1'b0, 8'h13, 0, 0, got);
        chk("LB13.k", got, 32'hFFFFFF80);
        run("LBU13", 1'b0, 2'b01, 1'b1, 8'h13, 0, 0, got);
        chk("LBU13.k", got, 32'h00000080);
        run("LB10", 1'b0, 2'b01, 1'b0, 8'h10, 0, 0, got);
        chk("LB10.k", got, 32'hFFFFFFF3);
        run("LH12", 1'b0, 2'b10, 1'b0, 8'h12, 0, 0, got);
        chk("LH12.k", got, 32'hFFFF8081);
        run("LHU12", 1'b0, 2'b10, 1'b1, 8'h12, 0, 0, got);
        chk("LHU12.k", got, 32'h00008081);
        run("LHU10", 1'b0, 2'b10, 1'b1, 8'h10, 0, 0, got);
        chk("LHU10.k", got, 32'h000082F3);

        // Stores
        run("SB21", 1'b1, 2'b01, 1'b0, 8'h21, 32'hFFFF_FFAB, 0, got);
        chk("SB21.k", mem[8], 32'h1122AB44);
        run("SW14", 1'b1, 2'b00, 1'b0, 8'h14, 32'hCAFE_F00D, 0, got);
        chk("SW14.k", mem[5], 32'hCAFEF00D);

        // Misaligned word load, reserved size, held response
        run("LW12", 1'b0, 2'b00, 1'b0, 8'h12, 0, 0, got);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("LW12.k", got, 32'h0);
`else
        chk("LW12.k", got, 32'h808182F3);
`endif
        run("LD10", 1'b0, 2'b11, 1'b0, 8'h10, 0, 0, got);
        run("HOLD", 1'b0, 2'b00, 1'b0, 8'h10, 0, 3, got);

        // Reset while a sub-word store is waiting for its read data
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b01;
        req_uns   = 1'b0;
        req_addr  = 32'h21;
        req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstw.rd", mem_rd, 0);
        chk("rstw.we", mem_we, 0);
        chk("rstw.rv", resp_valid, 0);
        chk("rstw.addr", mem_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstw.nowrite", mem[8], ref_word(8));
        run("LWrst", 1'b0, 2'b00, 1'b0, 8'h10, 0, 0, got);
        chk("LWrst.k", got, 32'h808182F3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            run("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
                $urandom_range(0, 2), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
